cpu_debug_controller: RTL and testbench

Run/halt/step controller and data-RAM arbiter that sits between the `cpu` core, its data RAM and a host debug command port. It gates the core's clock enable to halt, free-run, single/multi-step or stop on a PC breakpoint. While the core is halted, it gives the host exclusive read/write access to the data RAM through the core's single RAM port. Every accepted host command produces exactly one response.

---
 rtl/cpu_debug_controller_pkg.sv | 16 +
 rtl/cpu_debug_controller_if.sv | 17 +
 rtl/cpu_debug_controller_step_counter.sv | 19 +
 rtl/cpu_debug_controller.sv | 160 ++++++++++++++++
 tb/tb_cpu_debug_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_debug_controller_pkg.sv
// Shared definitions for the CPU debug controller: opcodes, FSM states and STATUS bit positions.
package dbg_pkg;
  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_RD_MEM = 3'd3;
  localparam logic [2:0] OP_WR_MEM = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5;
  localparam logic [2:0] OP_RD_PC  = 3'd6;
  localparam logic [2:0] OP_STATUS = 3'd7;

  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_MEM, S_RSP} state_e;

  localparam int ST_HALTED = 0;
  localparam int ST_BP_EN  = 1;
endpackage

// File: rtl/cpu_debug_controller_if.sv
// Host debug command/response port of the CPU debug controller.
interface cpu_debug_controller_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, rsp_err);
  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/cpu_debug_controller_step_counter.sv
// Loadable down-counter for multi-step; o_done marks the last step cycle.
module dbg_step_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (i_load)                r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == W'(1));
endmodule

// File: rtl/cpu_debug_controller.sv
// Run/halt/step controller for the core plus host-vs-core arbiter on the data-RAM port.
module cpu_debug_controller
  import dbg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_debug_controller_if.slave host,
  output logic                cpu_en,
  input  logic [ADDR_W-1:0]   cpu_pc,
  input  logic [ADDR_W-1:0]   cpu_ram_addr,
  input  logic [DATA_W-1:0]   cpu_ram_wdata,
  input  logic                cpu_ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_wen,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                halted
);
  state_e            r_state;
  logic              r_halted, r_bp_en, r_first, r_pend, r_err;
  logic              r_rsp_valid, r_rsp_err;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_bp_addr, r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata, r_rsp_data, w_rsp_d;
  logic              w_acc, w_bp_hit, w_cnt_load, w_cnt_done;

  assign w_acc      = host.cmd_valid & host.cmd_ready;
  assign w_bp_hit   = r_bp_en && (cpu_pc == r_bp_addr) && !r_first;
  assign w_cnt_load = (r_state == S_HALT) && w_acc && (host.cmd_op == OP_STEP);

  dbg_step_counter #(.W(ADDR_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_cnt_load),
    .i_val  (ADDR_W'(host.cmd_data)),
    .i_dec  (r_state == S_STEP),
    .o_done (w_cnt_done)
  );

  assign host.cmd_ready = (r_state == S_HALT || r_state == S_RUN) && !r_pend && !r_rsp_valid;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_data  = r_rsp_data;
  assign host.rsp_err   = r_rsp_err;
  assign halted         = r_halted;
  assign cpu_en         = (r_state == S_RUN && !w_bp_hit) || (r_state == S_STEP);

  assign ram_addr  = (r_state == S_MEM) ? r_addr  : cpu_ram_addr;
  assign ram_wdata = (r_state == S_MEM) ? r_wdata : cpu_ram_wdata;
  assign ram_wen   = (r_state == S_MEM) ? (r_op == OP_WR_MEM) : (cpu_ram_wen & cpu_en);

  // Payload is formed one cycle after acceptance so PC reads see the settled core.
  always_comb begin
    w_rsp_d = '0;
    case (r_op)
      OP_HALT, OP_STEP, OP_RD_PC: w_rsp_d = DATA_W'(cpu_pc);
      OP_RD_MEM:                  w_rsp_d = r_rdata;
      OP_STATUS: begin
        w_rsp_d[ST_HALTED] = r_halted;
        w_rsp_d[ST_BP_EN]  = r_bp_en;
      end
      default:                    w_rsp_d = '0;
    endcase
    if (r_err) w_rsp_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HALT;
      r_halted    <= 1'b1;
      r_bp_en     <= 1'b0;
      r_bp_addr   <= '0;
      r_first     <= 1'b0;
      r_pend      <= 1'b0;
      r_err       <= 1'b0;
      r_op        <= OP_HALT;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_first <= 1'b0;
      if (r_rsp_valid && host.rsp_ready) r_rsp_valid <= 1'b0;
      if (r_pend || r_state == S_RSP) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_rsp_d;
        r_rsp_err   <= r_err;
        r_pend      <= 1'b0;
      end
      case (r_state)
        S_HALT: if (w_acc) begin
          r_op    <= host.cmd_op;
          r_err   <= 1'b0;
          r_addr  <= host.cmd_addr;
          r_wdata <= host.cmd_data;
          case (host.cmd_op)
            OP_RUN: begin
              r_state  <= S_RUN;
              r_halted <= 1'b0;
              r_first  <= 1'b1;
              r_pend   <= 1'b1;
            end
            OP_STEP: begin
              if (host.cmd_data != '0) begin
                r_state  <= S_STEP;
                r_halted <= 1'b0;
              end else r_pend <= 1'b1;
            end
            OP_RD_MEM, OP_WR_MEM: begin
              r_state  <= S_MEM;
              r_halted <= 1'b0;
            end
            OP_SET_BP: begin
              r_bp_addr <= host.cmd_addr;
              r_bp_en   <= host.cmd_data[0];
              r_pend    <= 1'b1;
            end
            default: r_pend <= 1'b1;
          endcase
        end
        S_RUN: begin
          if (w_bp_hit) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
          if (w_acc) begin
            r_op   <= host.cmd_op;
            r_err  <= 1'b0;
            r_pend <= 1'b1;
            case (host.cmd_op)
              OP_HALT: begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end
              OP_SET_BP: begin
                r_bp_addr <= host.cmd_addr;
                r_bp_en   <= host.cmd_data[0];
              end
              OP_RD_MEM, OP_WR_MEM, OP_STEP: r_err <= 1'b1;
              default: ;
            endcase
          end
        end
        S_STEP: if (w_cnt_done) r_state <= S_RSP;
        S_MEM: begin
          r_rdata <= ram_rdata;
          r_state <= S_RSP;
        end
        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_debug_controller.sv
// Directed bench: PC-incrementing core model and a small RAM around the debug controller.
module tb_cpu_debug_controller;
  import dbg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_debug_controller_if #(.ADDR_W(16), .DATA_W(16)) h ();

  logic        cpu_en, ram_wen, halted;
  logic [15:0] pc, ram_addr, ram_wdata, ram_rdata;
  logic [15:0] mem [0:255];
  int          en_cnt, bad_wr;
  int          checks = 0;
  int          errors = 0;

  cpu_debug_controller #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (h),
    .cpu_en        (cpu_en),
    .cpu_pc        (pc),
    .cpu_ram_addr  (16'h0080),
    .cpu_ram_wdata (pc),
    .cpu_ram_wen   (1'b1),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_wen       (ram_wen),
    .ram_rdata     (ram_rdata),
    .halted        (halted)
  );

  // Core model: advances PC whenever enabled and requests a RAM write every cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (cpu_en) pc <= pc + 16'd1;

  assign ram_rdata = mem[ram_addr[7:0]];
  always @(posedge clk) if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;

  initial begin en_cnt = 0; bad_wr = 0; end
  always @(posedge clk) begin
    if (cpu_en) en_cnt <= en_cnt + 1;
    if (ram_wen && !cpu_en && ram_addr == 16'h0080) bad_wr <= bad_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    while (h.cmd_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("cmd_tmo", 32'(t >= 200), 0);
    h.cmd_valid = 1'b1; h.cmd_op = op; h.cmd_addr = a; h.cmd_data = d;
    @(posedge clk); #1;
    h.cmd_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] d, output logic e);
    int t = 0;
    while (h.rsp_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    chk("rsp_tmo", 32'(t >= 500), 0);
    d = h.rsp_data; e = h.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic re);
    send(op, a, d);
    recv(rd, re);
  endtask

  initial begin
    logic [15:0] rd, d0, p0;
    logic        re;
    int          n0, t;
    h.cmd_valid = 1'b0; h.cmd_op = '0; h.cmd_addr = '0; h.cmd_data = '0; h.rsp_ready = 1'b1;

    #12;
    chk("rst_halted", halted, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_cmd_ready", h.cmd_ready, 1);
    chk("rst_rsp_valid", h.rsp_valid, 0);
    chk("rst_rsp_err", h.rsp_err, 0);
    chk("rst_rsp_data", h.rsp_data, 0);
    @(negedge clk) rst_n = 1'b1;

    cmd(OP_STATUS, 0, 0, rd, re);
    chk("status_data", rd, 16'h0001);
    chk("status_err", re, 0);
    chk("status_cpu_en", cpu_en, 0);

    cmd(OP_WR_MEM, 16'h0010, 16'hBEEF, rd, re);
    chk("wr_rsp", rd, 0);
    chk("wr_mem", mem[16], 16'hBEEF);
    cmd(OP_RD_MEM, 16'h0010, 0, rd, re);
    chk("rd_data", rd, 16'hBEEF);
    chk("rd_err", re, 0);
    chk("no_core_wr_halted", bad_wr, 0);
    chk("pc_still", pc, 0);

    n0 = en_cnt;
    cmd(OP_STEP, 0, 16'd3, rd, re);
    chk("step3_pc", rd, 16'h0003);
    chk("step3_en_cycles", en_cnt - n0, 3);
    chk("step3_halted", halted, 1);
    n0 = en_cnt;
    cmd(OP_STEP, 0, 16'd0, rd, re);
    chk("step0_pc", rd, 16'h0003);
    chk("step0_en_cycles", en_cnt - n0, 0);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cmd(OP_SET_BP, 16'h0005, 16'h0001, rd, re);
    chk("setbp_rsp", rd, 0);
    cmd(OP_STATUS, 0, 0, rd, re);
    chk("status_bp", rd, 16'h0003);
    cmd(OP_RUN, 0, 0, rd, re);
    chk("run_rsp", rd, 0);
    chk("run_err", re, 0);
    t = 0;
    while (halted !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("bp_tmo", 32'(t >= 100), 0);
    chk("bp_pc", pc, 16'h0005);
    chk("bp_cpu_en", cpu_en, 0);
    cmd(OP_RD_PC, 0, 0, rd, re);
    chk("bp_rdpc", rd, 16'h0005);

    cmd(OP_RUN, 0, 0, rd, re);
    repeat (3) @(negedge clk);
    chk("resume_running", halted, 0);
    p0 = pc;
    cmd(OP_RD_MEM, 16'h0010, 0, rd, re);
    chk("run_rdmem_err", re, 1);
    chk("run_rdmem_data", rd, 0);
    chk("run_continues", 32'(pc > p0), 1);
    chk("run_not_halted", halted, 0);

    h.rsp_ready = 1'b0;
    send(OP_RD_PC, 0, 0);
    t = 0;
    while (h.rsp_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("bp_rsp_tmo", 32'(t >= 50), 0);
    d0 = h.rsp_data;
    p0 = pc;
    chk("bkp_rdpc_past_bp", 32'(d0 > 16'd5), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bkp_cmd_ready", h.cmd_ready, 0);
      chk("bkp_rsp_valid", h.rsp_valid, 1);
      chk("bkp_rsp_stable", h.rsp_data, d0);
    end
    chk("bkp_run_continues", 32'(pc > p0), 1);
    h.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bkp_retired", h.rsp_valid, 0);

    cmd(OP_HALT, 0, 0, rd, re);
    chk("halt_pc_gt5", 32'(rd > 16'd5), 1);
    chk("halt_pc_match", rd, pc);
    chk("halt_halted", halted, 1);
    chk("halt_cpu_en", cpu_en, 0);

    send(OP_STEP, 0, 16'd100);
    repeat (4) @(negedge clk);
    chk("step100_en", cpu_en, 1);
    chk("step100_halted", halted, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_halted", halted, 1);
    chk("rst_mid_cpu_en", cpu_en, 0);
    chk("rst_mid_rsp_valid", h.rsp_valid, 0);
    chk("rst_mid_cmd_ready", h.cmd_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    cmd(OP_STATUS, 0, 0, rd, re);
    chk("post_rst_status", rd, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
